chess_clock_top: RTL and testbench

Two-player chess clock core. It holds two independent 4-digit BCD countdown timers (MM:SS). A player-select input picks which timer decrements, one second per CE tick. Each timer drives four 7-segment digit outputs and a sticky time-expired flag. The block sits between the 1 Hz tick / button-conditioning logic and the board display pins.

---
 rtl/chess_clock_pkg.sv | 43 ++++
 rtl/bcd_countdown_timer.sv | 86 ++++++++
 rtl/chess_clock_top.sv | 80 ++++++++
 tb/tb_chess_clock_top.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// Shared types, default start time and 7-segment decoding for the chess clock.
package chess_clock_pkg;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // Default start time 05:00.
    localparam bcd_t DEF_MT = 4'd0;
    localparam bcd_t DEF_MO = 4'd5;
    localparam bcd_t DEF_ST = 4'd0;
    localparam bcd_t DEF_SO = 4'd0;

    // Active-high segment patterns, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Decode one BCD digit; non-decimal codes blank the digit.
    function automatic logic [6:0] seg7(input bcd_t d);
        case (d)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with a sticky expired flag; stops at 00:00.
module bcd_countdown_timer
    import chess_clock_pkg::*;
#(
    parameter bcd_t INIT_MT = DEF_MT,
    parameter bcd_t INIT_MO = DEF_MO,
    parameter bcd_t INIT_ST = DEF_ST,
    parameter bcd_t INIT_SO = DEF_SO
) (
    input  logic CLK,
    input  logic CLR,
    input  logic en,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic expired
);

    bcd_t mt_q, mo_q, st_q, so_q;
    bcd_t mt_d, mo_d, st_d, so_d;
    logic exp_q, exp_d;
    logic at_zero, at_one;

    assign at_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign at_one  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

    // Next time: one-second decrement with borrow chain, flag on reaching 00:00.
    always_comb begin
        mt_d  = mt_q;
        mo_d  = mo_q;
        st_d  = st_q;
        so_d  = so_q;
        exp_d = exp_q;
        if (en && !exp_q) begin
            if (at_zero) begin
                // Started at 00:00: the first tick just expires the timer.
                exp_d = 1'b1;
            end else begin
                if (at_one) begin
                    exp_d = 1'b1;
                end
                if (so_q != 4'd0) begin
                    so_d = so_q - 4'd1;
                end else begin
                    so_d = 4'd9;
                    if (st_q != 4'd0) begin
                        st_d = st_q - 4'd1;
                    end else begin
                        st_d = 4'd5;
                        if (mo_q != 4'd0) begin
                            mo_d = mo_q - 4'd1;
                        end else begin
                            mo_d = 4'd9;
                            mt_d = mt_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Digit and flag registers; reset reloads the start time.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            mt_q  <= INIT_MT;
            mo_q  <= INIT_MO;
            st_q  <= INIT_ST;
            so_q  <= INIT_SO;
            exp_q <= 1'b0;
        end else begin
            mt_q  <= mt_d;
            mo_q  <= mo_d;
            st_q  <= st_d;
            so_q  <= so_d;
            exp_q <= exp_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign expired  = exp_q;

endmodule

// File: rtl/chess_clock_top.sv
// Two-player chess clock: selects the running timer and drives 7-segment digits.
module chess_clock_top
    import chess_clock_pkg::*;
#(
    parameter int unsigned INIT_MT = 0,
    parameter int unsigned INIT_MO = 5,
    parameter int unsigned INIT_ST = 0,
    parameter int unsigned INIT_SO = 0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic       SELECT,
    input  logic       STOP,
    output logic       OVERFLOW1,
    output logic       OVERFLOW2,
    output logic [6:0] seg0_0,
    output logic [6:0] seg0_1,
    output logic [6:0] seg0_2,
    output logic [6:0] seg0_3,
    output logic [6:0] seg1_0,
    output logic [6:0] seg1_1,
    output logic [6:0] seg1_2,
    output logic [6:0] seg1_3
);

    localparam bcd_t P_MT = bcd_t'(INIT_MT);
    localparam bcd_t P_MO = bcd_t'(INIT_MO);
    localparam bcd_t P_ST = bcd_t'(INIT_ST);
    localparam bcd_t P_SO = bcd_t'(INIT_SO);

    bcd_t t0_mt, t0_mo, t0_st, t0_so;
    bcd_t t1_mt, t1_mo, t1_st, t1_so;
    logic exp0, exp1;
    logic run, en0, en1;

    // Any expired timer ends the game and freezes both clocks; STOP outranks CE.
    assign run = CE && !STOP && !exp0 && !exp1;
    assign en0 = run && !SELECT;
    assign en1 = run &&  SELECT;

    bcd_countdown_timer #(
        .INIT_MT(P_MT), .INIT_MO(P_MO), .INIT_ST(P_ST), .INIT_SO(P_SO)
    ) u_timer0 (
        .CLK      (CLK),
        .CLR      (CLR),
        .en       (en0),
        .min_tens (t0_mt),
        .min_ones (t0_mo),
        .sec_tens (t0_st),
        .sec_ones (t0_so),
        .expired  (exp0)
    );

    bcd_countdown_timer #(
        .INIT_MT(P_MT), .INIT_MO(P_MO), .INIT_ST(P_ST), .INIT_SO(P_SO)
    ) u_timer1 (
        .CLK      (CLK),
        .CLR      (CLR),
        .en       (en1),
        .min_tens (t1_mt),
        .min_ones (t1_mo),
        .sec_tens (t1_st),
        .sec_ones (t1_so),
        .expired  (exp1)
    );

    assign OVERFLOW1 = exp0;
    assign OVERFLOW2 = exp1;

    assign seg0_0 = seg7(t0_so);
    assign seg0_1 = seg7(t0_st);
    assign seg0_2 = seg7(t0_mo);
    assign seg0_3 = seg7(t0_mt);
    assign seg1_0 = seg7(t1_so);
    assign seg1_1 = seg7(t1_st);
    assign seg1_2 = seg7(t1_mo);
    assign seg1_3 = seg7(t1_mt);

endmodule

// File: tb/tb_chess_clock_top.sv
// Directed bench for chess_clock_top using four start times: 05:00, 00:03, 10:00, 00:00.
module tb_chess_clock_top;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    logic CE = 1'b0;
    logic SELECT = 1'b0;
    logic STOP = 1'b0;

    logic [6:0] a_t0 [4];
    logic [6:0] a_t1 [4];
    logic [6:0] b_t0 [4];
    logic [6:0] b_t1 [4];
    logic [6:0] c_t0 [4];
    logic [6:0] c_t1 [4];
    logic [6:0] d_t0 [4];
    logic [6:0] d_t1 [4];
    logic a_o1, a_o2, b_o1, b_o2, c_o1, c_o2, d_o1, d_o2;

    int n_checks = 0;
    int n_fail = 0;

    // Expected display words {MT, MO, ST, SO}.
    localparam logic [27:0] T_0500 = {7'h3F, 7'h6D, 7'h3F, 7'h3F};
    localparam logic [27:0] T_0459 = {7'h3F, 7'h66, 7'h6D, 7'h6F};
    localparam logic [27:0] T_0455 = {7'h3F, 7'h66, 7'h6D, 7'h6D};
    localparam logic [27:0] T_0450 = {7'h3F, 7'h66, 7'h6D, 7'h3F};
    localparam logic [27:0] T_0449 = {7'h3F, 7'h66, 7'h66, 7'h6F};
    localparam logic [27:0] T_0003 = {7'h3F, 7'h3F, 7'h3F, 7'h4F};
    localparam logic [27:0] T_0002 = {7'h3F, 7'h3F, 7'h3F, 7'h5B};
    localparam logic [27:0] T_0001 = {7'h3F, 7'h3F, 7'h3F, 7'h06};
    localparam logic [27:0] T_0000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] T_1000 = {7'h06, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] T_0959 = {7'h3F, 7'h6F, 7'h6D, 7'h6F};

    chess_clock_top u_a (
        .CLK(CLK), .CLR(CLR), .CE(CE), .SELECT(SELECT), .STOP(STOP),
        .OVERFLOW1(a_o1), .OVERFLOW2(a_o2),
        .seg0_0(a_t0[0]), .seg0_1(a_t0[1]), .seg0_2(a_t0[2]), .seg0_3(a_t0[3]),
        .seg1_0(a_t1[0]), .seg1_1(a_t1[1]), .seg1_2(a_t1[2]), .seg1_3(a_t1[3])
    );

    chess_clock_top #(.INIT_MT(0), .INIT_MO(0), .INIT_ST(0), .INIT_SO(3)) u_b (
        .CLK(CLK), .CLR(CLR), .CE(CE), .SELECT(SELECT), .STOP(STOP),
        .OVERFLOW1(b_o1), .OVERFLOW2(b_o2),
        .seg0_0(b_t0[0]), .seg0_1(b_t0[1]), .seg0_2(b_t0[2]), .seg0_3(b_t0[3]),
        .seg1_0(b_t1[0]), .seg1_1(b_t1[1]), .seg1_2(b_t1[2]), .seg1_3(b_t1[3])
    );

    chess_clock_top #(.INIT_MT(1), .INIT_MO(0), .INIT_ST(0), .INIT_SO(0)) u_c (
        .CLK(CLK), .CLR(CLR), .CE(CE), .SELECT(SELECT), .STOP(STOP),
        .OVERFLOW1(c_o1), .OVERFLOW2(c_o2),
        .seg0_0(c_t0[0]), .seg0_1(c_t0[1]), .seg0_2(c_t0[2]), .seg0_3(c_t0[3]),
        .seg1_0(c_t1[0]), .seg1_1(c_t1[1]), .seg1_2(c_t1[2]), .seg1_3(c_t1[3])
    );

    chess_clock_top #(.INIT_MT(0), .INIT_MO(0), .INIT_ST(0), .INIT_SO(0)) u_d (
        .CLK(CLK), .CLR(CLR), .CE(CE), .SELECT(SELECT), .STOP(STOP),
        .OVERFLOW1(d_o1), .OVERFLOW2(d_o2),
        .seg0_0(d_t0[0]), .seg0_1(d_t0[1]), .seg0_2(d_t0[2]), .seg0_3(d_t0[3]),
        .seg1_0(d_t1[0]), .seg1_1(d_t1[1]), .seg1_2(d_t1[2]), .seg1_3(d_t1[3])
    );

    always #5 CLK = ~CLK;

    // One clock edge, then settle 1 ns past it before anything is sampled.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Pulse reset between edges and release it before the next edge.
    task automatic do_reset();
        CE = 1'b0;
        STOP = 1'b0;
        SELECT = 1'b0;
        @(negedge CLK);
        CLR = 1'b0;
        #2;
        CLR = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        CLR = 1'b0;
        tick(2);
        n_checks++;
        if ({a_t0[3], a_t0[2], a_t0[1], a_t0[0]} !== T_0500) begin
            n_fail++;
            $display("FAIL reset_t0 got=%h exp=%h", {a_t0[3], a_t0[2], a_t0[1], a_t0[0]}, T_0500);
        end
        n_checks++;
        if ({a_t1[3], a_t1[2], a_t1[1], a_t1[0]} !== T_0500) begin
            n_fail++;
            $display("FAIL reset_t1 got=%h exp=%h", {a_t1[3], a_t1[2], a_t1[1], a_t1[0]}, T_0500);
        end
        n_checks++;
        if ({a_o1, a_o2} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=00", {a_o1, a_o2});
        end
        n_checks++;
        if ({b_t0[3], b_t0[2], b_t0[1], b_t0[0]} !== T_0003) begin
            n_fail++;
            $display("FAIL reset_init_param got=%h exp=%h", {b_t0[3], b_t0[2], b_t0[1], b_t0[0]}, T_0003);
        end
        @(negedge CLK);
        CLR = 1'b1;
    endtask

    task automatic test_single_player();
        do_reset();
        CE = 1'b1;
        SELECT = 1'b0;
        tick(1);
        CE = 1'b0;
        n_checks++;
        if ({a_t0[3], a_t0[2], a_t0[1], a_t0[0]} !== T_0459) begin
            n_fail++;
            $display("FAIL single_t0 got=%h exp=%h", {a_t0[3], a_t0[2], a_t0[1], a_t0[0]}, T_0459);
        end
        n_checks++;
        if ({a_t1[3], a_t1[2], a_t1[1], a_t1[0]} !== T_0500) begin
            n_fail++;
            $display("FAIL single_t1_hold got=%h exp=%h", {a_t1[3], a_t1[2], a_t1[1], a_t1[0]}, T_0500);
        end
    endtask

    task automatic test_alternation();
        do_reset();
        CE = 1'b1;
        SELECT = 1'b1;
        tick(5);
        n_checks++;
        if ({a_t1[3], a_t1[2], a_t1[1], a_t1[0]} !== T_0455) begin
            n_fail++;
            $display("FAIL alt_t1_mid got=%h exp=%h", {a_t1[3], a_t1[2], a_t1[1], a_t1[0]}, T_0455);
        end
        SELECT = 1'b0;
        tick(10);
        SELECT = 1'b1;
        tick(5);
        CE = 1'b0;
        n_checks++;
        if ({a_t0[3], a_t0[2], a_t0[1], a_t0[0]} !== T_0450) begin
            n_fail++;
            $display("FAIL alt_t0 got=%h exp=%h", {a_t0[3], a_t0[2], a_t0[1], a_t0[0]}, T_0450);
        end
        n_checks++;
        if ({a_t1[3], a_t1[2], a_t1[1], a_t1[0]} !== T_0450) begin
            n_fail++;
            $display("FAIL alt_t1 got=%h exp=%h", {a_t1[3], a_t1[2], a_t1[1], a_t1[0]}, T_0450);
        end
    endtask

    // Continues from 04:50 / 04:50 left by test_alternation.
    task automatic test_pause();
        CE = 1'b1;
        STOP = 1'b1;
        SELECT = 1'b0;
        tick(5);
        n_checks++;
        if ({a_t0[3], a_t0[2], a_t0[1], a_t0[0], a_t1[0]} !== {T_0450, 7'h3F}) begin
            n_fail++;
            $display("FAIL stop_hold got=%h exp=%h", {a_t0[3], a_t0[2], a_t0[1], a_t0[0], a_t1[0]}, {T_0450, 7'h3F});
        end
        STOP = 1'b0;
        tick(1);
        n_checks++;
        if ({a_t0[3], a_t0[2], a_t0[1], a_t0[0]} !== T_0449) begin
            n_fail++;
            $display("FAIL stop_resume got=%h exp=%h", {a_t0[3], a_t0[2], a_t0[1], a_t0[0]}, T_0449);
        end
        CE = 1'b0;
        tick(3);
        n_checks++;
        if ({a_t0[3], a_t0[2], a_t0[1], a_t0[0]} !== T_0449) begin
            n_fail++;
            $display("FAIL ce_low_hold got=%h exp=%h", {a_t0[3], a_t0[2], a_t0[1], a_t0[0]}, T_0449);
        end
    endtask

    task automatic test_expiry();
        do_reset();
        CE = 1'b1;
        SELECT = 1'b1;
        tick(1);
        n_checks++;
        if ({b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2} !== {T_0002, 1'b0}) begin
            n_fail++;
            $display("FAIL exp_step1 got=%h exp=%h", {b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2}, {T_0002, 1'b0});
        end
        tick(1);
        n_checks++;
        if ({b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2} !== {T_0001, 1'b0}) begin
            n_fail++;
            $display("FAIL exp_step2 got=%h exp=%h", {b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2}, {T_0001, 1'b0});
        end
        tick(1);
        n_checks++;
        if ({b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2} !== {T_0000, 1'b1}) begin
            n_fail++;
            $display("FAIL exp_flag got=%h exp=%h", {b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2}, {T_0000, 1'b1});
        end
        SELECT = 1'b0;
        tick(3);
        n_checks++;
        if ({b_t0[3], b_t0[2], b_t0[1], b_t0[0], b_o1, b_o2} !== {T_0003, 2'b01}) begin
            n_fail++;
            $display("FAIL exp_freeze got=%h exp=%h", {b_t0[3], b_t0[2], b_t0[1], b_t0[0], b_o1, b_o2}, {T_0003, 2'b01});
        end
        n_checks++;
        if ({b_t1[3], b_t1[2], b_t1[1], b_t1[0]} !== T_0000) begin
            n_fail++;
            $display("FAIL exp_hold_zero got=%h exp=%h", {b_t1[3], b_t1[2], b_t1[1], b_t1[0]}, T_0000);
        end
        // Asynchronous reset mid-cycle, observed before any clock edge.
        @(negedge CLK);
        #1;
        CLR = 1'b0;
        #1;
        n_checks++;
        if ({b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2} !== {T_0003, 1'b0}) begin
            n_fail++;
            $display("FAIL async_clear got=%h exp=%h", {b_t1[3], b_t1[2], b_t1[1], b_t1[0], b_o2}, {T_0003, 1'b0});
        end
        n_checks++;
        if ({a_t0[3], a_t0[2], a_t0[1], a_t0[0]} !== T_0500) begin
            n_fail++;
            $display("FAIL async_reload got=%h exp=%h", {a_t0[3], a_t0[2], a_t0[1], a_t0[0]}, T_0500);
        end
        CE = 1'b0;
        #1;
        CLR = 1'b1;
    endtask

    task automatic test_borrow();
        do_reset();
        n_checks++;
        if ({c_t0[3], c_t0[2], c_t0[1], c_t0[0]} !== T_1000) begin
            n_fail++;
            $display("FAIL borrow_init got=%h exp=%h", {c_t0[3], c_t0[2], c_t0[1], c_t0[0]}, T_1000);
        end
        CE = 1'b1;
        SELECT = 1'b0;
        tick(1);
        SELECT = 1'b1;
        tick(1);
        CE = 1'b0;
        n_checks++;
        if ({c_t0[3], c_t0[2], c_t0[1], c_t0[0]} !== T_0959) begin
            n_fail++;
            $display("FAIL borrow_t0 got=%h exp=%h", {c_t0[3], c_t0[2], c_t0[1], c_t0[0]}, T_0959);
        end
        n_checks++;
        if ({c_t1[3], c_t1[2], c_t1[1], c_t1[0]} !== T_0959) begin
            n_fail++;
            $display("FAIL borrow_t1 got=%h exp=%h", {c_t1[3], c_t1[2], c_t1[1], c_t1[0]}, T_0959);
        end
    endtask

    task automatic test_zero_start();
        do_reset();
        tick(2);
        n_checks++;
        if ({d_o1, d_o2} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_reset_flags got=%b exp=00", {d_o1, d_o2});
        end
        CE = 1'b1;
        SELECT = 1'b0;
        tick(1);
        n_checks++;
        if ({d_t0[3], d_t0[2], d_t0[1], d_t0[0], d_o1, d_o2} !== {T_0000, 2'b10}) begin
            n_fail++;
            $display("FAIL zero_first_tick got=%h exp=%h", {d_t0[3], d_t0[2], d_t0[1], d_t0[0], d_o1, d_o2}, {T_0000, 2'b10});
        end
        SELECT = 1'b1;
        tick(2);
        CE = 1'b0;
        n_checks++;
        if ({d_t1[3], d_t1[2], d_t1[1], d_t1[0], d_o1, d_o2} !== {T_0000, 2'b10}) begin
            n_fail++;
            $display("FAIL zero_game_over got=%h exp=%h", {d_t1[3], d_t1[2], d_t1[1], d_t1[0], d_o1, d_o2}, {T_0000, 2'b10});
        end
    endtask

    initial begin
        test_reset();
        test_single_player();
        test_alternation();
        test_pause();
        test_expiry();
        test_borrow();
        test_zero_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
